// File: rtl/alu_share_arbiter_if.sv
// ============================================================================
// alu_share_arbiter_if : client request, ALU and response signals of the arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface alu_share_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
);
  logic              req0;
  logic              req1;
  logic [DATA_W-1:0] a0;
  logic [DATA_W-1:0] b0;
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] b1;
  logic [CTRL_W-1:0] ctrl0;
  logic [CTRL_W-1:0] ctrl1;
  logic              gnt0;
  logic              gnt1;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_ready;

  modport master (
    output req0, req1, a0, b0, a1, b1, ctrl0, ctrl1, alu_result, alu_zero, rsp_ready,
    input  gnt0, gnt1, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_result, rsp_zero
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, ctrl0, ctrl1, alu_result, alu_zero, rsp_ready,
    output gnt0, gnt1, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_id, rsp_result, rsp_zero
  );
endinterface

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// alu_share_arbiter : two-client arbiter/sequencer for one shared combinational ALU
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority to client 0 (default round-robin)
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
  parameter int                DATA_W    = 32,
  parameter int                CTRL_W    = 4,
  parameter logic [CTRL_W-1:0] IDLE_CTRL = {CTRL_W{1'b1}}
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  alu_share_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_id;
  logic [DATA_W-1:0] r_rsp_result;
  logic              r_rsp_zero;
  logic              r_rsp_id;
  logic              w_sample;
  logic              w_grant;
  logic              w_win;

  assign w_sample = (r_state == ST_IDLE) || ((r_state == ST_RESP) && bus.rsp_ready);
  // rst_n in the term keeps the grant pulses low while reset is held
  assign w_grant  = w_sample && (bus.req0 || bus.req1) && rst_n;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_win = ~bus.req0;
`else
  logic r_last_gnt;

  assign w_win = (bus.req0 && bus.req1) ? ~r_last_gnt : bus.req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= 1'b1;
    end else if (w_grant) begin
      r_last_gnt <= w_win;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_grant) r_state <= ST_EXEC;
        ST_EXEC: r_state <= ST_RESP;
        ST_RESP: if (bus.rsp_ready) r_state <= w_grant ? ST_EXEC : ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_ctrl <= IDLE_CTRL;
      r_id   <= 1'b0;
    end else if (w_grant) begin
      r_a    <= w_win ? bus.a1    : bus.a0;
      r_b    <= w_win ? bus.b1    : bus.b0;
      r_ctrl <= w_win ? bus.ctrl1 : bus.ctrl0;
      r_id   <= w_win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_id     <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_rsp_result <= bus.alu_result;
      r_rsp_zero   <= bus.alu_zero;
      r_rsp_id     <= r_id;
    end
  end

  assign bus.gnt0       = w_grant && !w_win;
  assign bus.gnt1       = w_grant &&  w_win;
  assign bus.alu_a      = r_a;
  assign bus.alu_b      = r_b;
  // Idle code outside EXEC forces a control transition for every operation
  assign bus.alu_ctrl   = (r_state == ST_EXEC) ? r_ctrl : IDLE_CTRL;
  assign bus.rsp_valid  = (r_state == ST_RESP);
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_zero   = r_rsp_zero;

endmodule

`default_nettype wire

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter and sequencer for the shared combinational 32-bit ALU. It accepts operation requests (A, B, 4-bit control) from two clients, grants one at a time, and drives the ALU operand and control inputs for one execute cycle. It then registers the result and zero flag and returns them through a single response channel with backpressure. It sits between the issue logic and the ALU instance.

## Interface
- DATA_W, 32: operand and result width.
- CTRL_W, 4: ALU control width.
- IDLE_CTRL, 4'hF: ALU control code driven outside the execute cycle. It must not be a valid ALU opcode.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  request valid from client 0 / 1; held until granted.
- a0, b0 / a1, b1  in  DATA_W  operands of client 0 / 1.
- ctrl0 / ctrl1  in  CTRL_W  ALU control of client 0 / 1.
- gnt0 / gnt1  out  1  one-cycle accept pulse; operands are captured on that edge.
- alu_a, alu_b  out  DATA_W  operands to the ALU.
- alu_ctrl  out  CTRL_W  control to the ALU.
- alu_result  in  DATA_W  ALU output, combinational from alu_a/alu_b/alu_ctrl.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response holds valid data.
- rsp_id  out  1  client the response belongs to (0/1).
- rsp_result  out  DATA_W  registered ALU result.
- rsp_zero  out  1  registered zero flag.
- rsp_ready  in  1  consumer accepts the response.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - If any reqN is high, select a winner.
  - Pulse gntN in that cycle.
  - Latch the winner's a, b, ctrl and id into the operand registers.
  - Go to EXEC.
- **EXEC** (exactly one cycle):
  - alu_a and alu_b come from the operand registers; alu_ctrl comes from the latched ctrl.
  - On the clock edge, capture alu_result into rsp_result, alu_zero into rsp_zero, and the latched id into rsp_id.
  - Go to RESP.
- **RESP:**
  - rsp_valid is high. rsp_result, rsp_zero and rsp_id are stable until accepted.
  - If rsp_ready is low, stay in RESP.
  - If rsp_ready is high and a reqN is pending, select, grant and latch as in IDLE in the same cycle, then go to EXEC.
  - If rsp_ready is high and no request is pending, go to IDLE.
- **Outside EXEC:** alu_ctrl = IDLE_CTRL. alu_a and alu_b hold the last latched operands. Every operation therefore presents a control transition to the ALU.
- **Arbitration (default round-robin):**
  - A one-bit last_gnt register records the last client granted.
  - If both clients request, the client other than last_gnt wins.
  - If one client requests, it wins.
  - last_gnt updates on every grant.
- No grant is ever issued in EXEC, or in RESP while rsp_ready is low.
- Arithmetic is performed entirely by the ALU. The block only forwards values; there is no width conversion.

## Timing
- **Reset values:** FSM = IDLE, gnt0 = gnt1 = 0, rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_zero = 0, alu_a = alu_b = 0, alu_ctrl = IDLE_CTRL, last_gnt = 1 (client 0 wins the first contest).
- **Latency:** request seen in IDLE → rsp_valid high 2 cycles later.
- **Throughput:** with rsp_ready tied high, one operation every 2 cycles (RESP→EXEC→RESP).
- **Handshakes:** reqN is sampled only in IDLE, or in RESP with rsp_ready high. A client must hold reqN and its operands until it sees gntN. A client may deassert reqN after gntN, or keep it asserted for a back-to-back request.
- **Reset mid-operation:** asserting rst_n low in EXEC or RESP discards the in-flight operation and the pending response immediately; all outputs return to reset values asynchronously.
- **Simultaneous request deassert:** if reqN drops in the same cycle the other client is granted, there is no effect.

## Configuration
- **ALU_ARB_FIXED_PRIO_EN:**
  - When defined, client 0 always wins when both clients request. last_gnt is not implemented, and client 1 can starve.
  - When undefined, round-robin as specified above.

## Test plan
- **Reset:** assert rst_n low mid-RESP → rsp_valid = 0, alu_ctrl = 4'hF, FSM IDLE; next request is serviced normally.
- **Single request:** req0 with a0 = 5, b0 = 3, ctrl0 = add → gnt0 pulses at T, rsp_valid at T+2 with rsp_result = 8, rsp_zero = 0, rsp_id = 0.
- **Zero flag:** req1 with a1 = 7, b1 = 7, ctrl1 = sub → rsp_result = 0, rsp_zero = 1, rsp_id = 1.
- **Contention:** req0 and req1 held continuously, rsp_ready = 1 → grant order 0, 1, 0, 1, one grant every 2 cycles. With ALU_ARB_FIXED_PRIO_EN → grants are 0, 0, 0, ….
- **Backpressure:** rsp_ready = 0 for 5 cycles with req1 pending → rsp fields are stable, no gnt1; rsp_ready = 1 → gnt1 in the same cycle, new response 2 cycles later.
- **Control transition:** two identical back-to-back requests → alu_ctrl shows IDLE_CTRL between the two EXEC cycles, and both responses are correct.
